pwm_duty_ramp_ctrl: RTL
=======================

// Module: pwm_duty_ramp_ctrl
// PURPOSE
//  Duty-cycle sequencer for the 10-step PWM generator. Holds a target duty, moves the
//  live duty one step at a time toward it, and changes duty only on PWM period boundaries.
//  Takes targets from a valid/ready port (host/FSM) and from debounced inc/dec pulses.
//  Sits between the button debouncers / control logic and the PWM counter/comparator.
// PARAMETERS
//  DUTY_W     4   width of duty values
//  DUTY_MAX   10  maximum duty code (100%); all targets clamp to this
//  RAMP_DIV   2   period ticks per duty step; legal range >= 1
//  INIT_DUTY  5   duty code after reset (50%); must be <= DUTY_MAX
// PORTS
//  clk          in   1       system clock (100 MHz)
//  rst_n        in   1       synchronous, active-low reset
//  period_tick  in   1       1-clk pulse when the PWM counter wraps to 0
//  tgt_valid    in   1       new absolute target offered
//  tgt_ready    out  1       target accepted when tgt_valid & tgt_ready
//  tgt_duty     in   DUTY_W  absolute target duty code
//  inc_pulse    in   1       debounced 1-clk pulse: target+1
//  dec_pulse    in   1       debounced 1-clk pulse: target-1
//  duty_out     out  DUTY_W  live duty code to the PWM comparator
//  busy         out  1       high while duty_out != target
//  at_target    out  1       1-clk pulse when a ramp completes
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): duty_out=INIT_DUTY, target=INIT_DUTY, state=IDLE,
//    div_cnt=0, tgt_ready=1, busy=0, at_target=0. Reset mid-ramp aborts the ramp.
//  - tgt_ready is 1 in every state outside reset: a new target retargets a ramp in progress.
//  - Target update (registered next clk), priority: handshake > inc/dec. Handshake loads
//    min(tgt_duty, DUTY_MAX). inc & dec in the same clk cancel. inc saturates at DUTY_MAX.
//    dec saturates at 0. inc/dec apply to the current target, not to duty_out.
//  - FSM, decided each clk from the registered target: IDLE (duty==target),
//    UP (duty<target), DOWN (duty>target).
//    IDLE->UP/DOWN clears div_cnt. UP<->DOWN reversal keeps div_cnt.
//  - Step: in UP/DOWN, on period_tick, if div_cnt==RAMP_DIV-1 then duty_out +/-1 and
//    div_cnt=0; otherwise div_cnt+1. duty_out never changes except in a period_tick clk.
//    First step lands on the RAMP_DIV-th tick after entry.
//  - Exit: the clk after duty_out reaches the target, the state returns to IDLE and
//    at_target pulses for 1 clk. busy = (state != IDLE), registered.
//  - Latency: target change accepted at clk N -> busy=1 at N+2 (target reg at N+1, FSM at N+2).
//  - Target equal to the current duty: no ramp, no at_target pulse.
//  - Arithmetic: unsigned DUTY_W; duty_out stays in 0..DUTY_MAX at all times.
// CONFIGURATION
//  PWM_SOFT_START_EN defined: reset sets duty_out=0 and target=INIT_DUTY, so the block
//    ramps 0->INIT_DUTY after reset (busy=1, at_target pulses on arrival).
//  Not defined: duty_out=INIT_DUTY directly at reset, state IDLE.
// STRUCTURE
//  Shared package pwm_ctrl_pkg: state encoding (IDLE/UP/DOWN) and the DUTY_W/DUTY_MAX
//    defaults, also used by the PWM generator.
//  One sub-module, pwm_step_divider: counts period_tick and emits step_en every RAMP_DIV
//    ticks, with a clear input. FSM and target logic stay in the top module.
// TESTING (RAMP_DIV=2, INIT_DUTY=5, period_tick every 10 clk)
//  1 reset, no macro -> duty_out=5, busy=0, tgt_ready=1, at_target=0.
//  2 tgt_duty=8 accepted -> duty_out 6/7/8 on the 2nd/4th/6th tick, one at_target pulse,
//    then busy=0.
//  3 tgt_duty=15 -> clamps to 10; ramps 5->10 in 10 ticks; duty_out never exceeds 10.
//  4 ramp 5->9; at duty_out=7 send tgt_duty=3 -> DOWN, no step skipped, ends at 3,
//    exactly one at_target pulse.
//  5 IDLE at 5: inc&dec same clk -> no change. Target 10 + inc -> stays 10.
//    Target 0 + dec -> stays 0. Handshake + inc same clk -> handshake value wins.
//  6 rst_n=0 mid-ramp -> next clk duty_out=5, IDLE. With PWM_SOFT_START_EN -> duty_out=0,
//    ramps to 5, at_target pulses.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: duty defaults and ramp state encoding shared by the PWM generator blocks.
package pwm_ctrl_pkg;
  localparam int DUTY_W_DEF   = 4;
  localparam int DUTY_MAX_DEF = 10;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } ramp_state_t;
endpackage

// File: rtl/pwm_step_divider.sv
// pwm_step_divider: counts period ticks and fires step_en on every RAMP_DIV-th tick while not cleared.
module pwm_step_divider #(
  parameter int RAMP_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic tick,
  output logic step_en
);
  localparam int CW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);
  logic [CW-1:0] cnt;
  assign step_en = !clr && tick && cnt == LAST;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : !tick ? cnt : cnt == LAST ? '0 : cnt + 1'b1;
endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// pwm_duty_ramp_ctrl: ramps the live PWM duty one step per RAMP_DIV period ticks toward a target.
// Define PWM_SOFT_START_EN to start from duty 0 after reset and ramp up to INIT_DUTY.
module pwm_duty_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int DUTY_W    = DUTY_W_DEF,
  parameter int DUTY_MAX  = DUTY_MAX_DEF,
  parameter int RAMP_DIV  = 2,
  parameter int INIT_DUTY = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              period_tick,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic [DUTY_W-1:0] tgt_duty,
  input  logic              inc_pulse,
  input  logic              dec_pulse,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              at_target
);
  localparam logic [DUTY_W-1:0] MAX_C  = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] INIT_C = DUTY_W'(INIT_DUTY);
  logic [DUTY_W-1:0] target, target_nxt, tgt_clamp;
  ramp_state_t state, state_nxt;
  logic step_en;
  assign tgt_ready = 1'b1;
  always_comb begin
    tgt_clamp  = tgt_duty > MAX_C ? MAX_C : tgt_duty;
    target_nxt = (tgt_valid && tgt_ready) ? tgt_clamp :
                 (inc_pulse && !dec_pulse) ? (target == MAX_C ? target : target + 1'b1) :
                 (dec_pulse && !inc_pulse) ? (target == '0 ? target : target - 1'b1) : target;
    state_nxt  = duty_out < target ? UP : duty_out > target ? DOWN : IDLE;
  end
  // Divider is held clear in IDLE so every ramp starts counting ticks from zero.
  pwm_step_divider #(.RAMP_DIV(RAMP_DIV)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state == IDLE),
    .tick   (period_tick),
    .step_en(step_en)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
`ifdef PWM_SOFT_START_EN
      duty_out  <= '0;
`else
      duty_out  <= INIT_C;
`endif
      target    <= INIT_C;
      state     <= IDLE;
      busy      <= 1'b0;
      at_target <= 1'b0;
    end else begin
      target    <= target_nxt;
      state     <= state_nxt;
      busy      <= state_nxt != IDLE;
      at_target <= state != IDLE && state_nxt == IDLE;
      if (step_en)
        duty_out <= state_nxt == UP ? duty_out + 1'b1 : state_nxt == DOWN ? duty_out - 1'b1 : duty_out;
    end
endmodule
